// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: WIDTH-bit add/subtract built from one shared SLICE-bit
// carry-lookahead adder slice. The slice is time-shared least-significant
// slice first. The carry between slices is held in a register. The sum and
// the Y86 condition flags are returned over a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1, slice outputs forced to 0
// RUN    | one slice per cycle, r_idx selects the slice, r_carry feeds cin
// DONE   | registered result and flags presented, waiting for resp_ready
//
// WIDTH must be an integer multiple of SLICE, and WIDTH/SLICE must be at
// least 2.

module cla_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_zf,
  output logic             resp_sf,
  output logic             resp_of,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SHW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = {{(WIDTH-SLICE){1'b0}}, {SLICE{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_resp_sum;
  logic             r_resp_cout;
  logic             r_resp_zf;
  logic             r_resp_sf;
  logic             r_resp_of;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;
  logic [WIDTH-1:0] w_slice_ext;
  logic [WIDTH-1:0] w_result_next;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = req_valid & req_ready;

  // Bit offset of the active slice. A shift is used instead of a variable
  // part-select so the slice position stays generic in WIDTH and SLICE.
  assign w_shamt     = SHW'(r_idx) * SHW'(SLICE);
  assign w_a_shr     = r_a >> w_shamt;
  assign w_b_shr     = r_b >> w_shamt;
  assign w_slice_ext = {{(WIDTH-SLICE){1'b0}}, slice_sum} << w_shamt;

  // Result with the active slice replaced by this cycle's slice sum.
  // On the last RUN cycle this value is the complete result.
  assign w_result_next = (r_result & ~(SLICE_MASK << w_shamt)) | w_slice_ext;

  // Drive the adder slice only during RUN. IDLE and DONE present zeros.
  assign slice_a   = w_run ? w_a_shr[SLICE-1:0] : '0;
  assign slice_b   = w_run ? w_b_shr[SLICE-1:0] : '0;
  assign slice_cin = w_run ? r_carry : 1'b0;

  assign resp_sum  = r_resp_sum;
  assign resp_cout = r_resp_cout;
  assign resp_zf   = r_resp_zf;
  assign resp_sf   = r_resp_sf;
  assign resp_of   = r_resp_of;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the handshake/status outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operands, slice index, inter-slice carry and the partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1. The +1 enters as the carry into slice 0.
      r_a     <= req_a;
      r_b     <= req_sub ? ~req_b : req_b;
      r_carry <= req_sub;
      r_idx   <= '0;
    end else if (w_run) begin
      r_result <= w_result_next;
      r_carry  <= slice_cout;
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Response registers are loaded on the last RUN edge. They hold their
  // value through DONE and after it, until the next operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_sum  <= '0;
      r_resp_cout <= 1'b0;
      r_resp_zf   <= 1'b0;
      r_resp_sf   <= 1'b0;
      r_resp_of   <= 1'b0;
    end else if (w_run && w_last) begin
      r_resp_sum  <= w_result_next;
      r_resp_cout <= slice_cout;
      r_resp_zf   <= (w_result_next == '0);
      r_resp_sf   <= w_result_next[WIDTH-1];
      r_resp_of   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Testbench for cla_slice_sequencer, configured with WIDTH=32 and SLICE=16.
// Expected results come from signed and unsigned integer arithmetic on the
// full operands. The adder slice is modelled as a plain combinational adder.

module tb_cla_slice_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_sub;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_sum;
  logic        resp_cout;
  logic        resp_zf;
  logic        resp_sf;
  logic        resp_of;
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic        slice_cin;
  logic [15:0] slice_sum;
  logic        slice_cout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cla_slice_sequencer #(.WIDTH(32), .SLICE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_zf    (resp_zf),
    .resp_sf    (resp_sf),
    .resp_of    (resp_of),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .busy       (busy)
  );

  // External adder slice: purely combinational, same-cycle result.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {16'd0, slice_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation. Called at a falling edge; returns at the falling
  // edge after the response handshake. 'hold' is the number of DONE cycles
  // spent with resp_ready low while new requests are offered and must be
  // ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input int hold);
    logic [31:0] bp;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_of;
    logic        low_carry;
    logic [32:0] wide;
    longint      sa;
    longint      sb;
    longint      sr;
    int          n;

    bp = sub ? ~b : b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      exp_sum   = a - b;
      exp_cout  = (a >= b);
      sr        = sa - sb;
      low_carry = (a[15:0] >= b[15:0]);
    end else begin
      wide      = {1'b0, a} + {1'b0, b};
      exp_sum   = wide[31:0];
      exp_cout  = wide[32];
      sr        = sa + sb;
      low_carry = (({1'b0, a[15:0]} + {1'b0, b[15:0]}) > 17'h0FFFF);
    end
    exp_of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);

    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'd0, req_ready}, 64'd1);

    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    @(negedge clk);
    // RUN cycle 0. The request inputs are now scrambled and must be ignored.
    chk("run0_busy",  {63'd0, busy}, 64'd1);
    chk("run0_ready", {63'd0, req_ready}, 64'd0);
    chk("run0_valid", {63'd0, resp_valid}, 64'd0);
    chk("run0_a",     {48'd0, slice_a}, {48'd0, a[15:0]});
    chk("run0_b",     {48'd0, slice_b}, {48'd0, bp[15:0]});
    chk("run0_cin",   {63'd0, slice_cin}, {63'd0, sub});
    req_valid = 1'($urandom_range(0, 1));
    req_a     = $urandom;
    req_b     = $urandom;
    req_sub   = 1'($urandom_range(0, 1));
    @(negedge clk);
    // RUN cycle 1
    chk("run1_valid", {63'd0, resp_valid}, 64'd0);
    chk("run1_a",     {48'd0, slice_a}, {48'd0, a[31:16]});
    chk("run1_b",     {48'd0, slice_b}, {48'd0, bp[31:16]});
    chk("run1_cin",   {63'd0, slice_cin}, {63'd0, low_carry});
    resp_ready = 1'b0;
    @(negedge clk);
    // DONE
    chk("done_valid", {63'd0, resp_valid}, 64'd1);
    chk("done_busy",  {63'd0, busy}, 64'd1);
    chk("done_sum",   {32'd0, resp_sum}, {32'd0, exp_sum});
    chk("done_cout",  {63'd0, resp_cout}, {63'd0, exp_cout});
    chk("done_zf",    {63'd0, resp_zf}, {63'd0, (exp_sum == 32'd0)});
    chk("done_sf",    {63'd0, resp_sf}, {63'd0, exp_sum[31]});
    chk("done_of",    {63'd0, resp_of}, {63'd0, exp_of});
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_a      = $urandom;
      req_b      = $urandom;
      req_sub    = 1'($urandom_range(0, 1));
      resp_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_sum",   {32'd0, resp_sum}, {32'd0, exp_sum});
      chk("hold_flags", {60'd0, resp_cout, resp_zf, resp_sf, resp_of},
                        {60'd0, exp_cout, (exp_sum == 32'd0), exp_sum[31], exp_of});
    end
    resp_ready = 1'b1;
    if (hold == 0) begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    resp_ready = 1'b0;
    // Back in IDLE; the result stays visible but is no longer qualified.
    chk("post_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_ready", {63'd0, req_ready}, 64'd1);
    chk("post_busy",  {63'd0, busy}, 64'd0);
    chk("post_sum",   {32'd0, resp_sum}, {32'd0, exp_sum});
    chk("post_slice", {47'd0, slice_a, slice_cin}, 64'd0);
  endtask

  initial begin
    logic [31:0] corners [4];
    logic [31:0] ra;
    logic [31:0] rb;

    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_resp",  {28'd0, resp_sum, resp_cout, resp_zf, resp_sf, resp_of}, 64'd0);
    chk("rst_slice", {31'd0, slice_a, slice_b, slice_cin}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", {63'd0, req_ready}, 64'd1);

    // Directed cases
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0);
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);

    // Backpressure: the pending req_valid stays high through the release
    // edge and is taken by the following operation.
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 3);
    chk("pend_valid_held", {63'd0, req_valid}, 64'd1);
    run_op(32'h0000_8000, 32'h0000_8000, 1'b0, 0);

    // Reset during RUN cycle 0: no response, partial result discarded.
    req_valid = 1'b1;
    req_a     = 32'h0001_0001;
    req_b     = 32'h0002_0002;
    req_sub   = 1'b0;
    @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mid_rst_state", {61'd0, req_ready, resp_valid, busy}, 64'd4);
    chk("mid_rst_resp",  {32'd0, resp_sum}, 64'd0);
    chk("mid_rst_slice", {31'd0, slice_a, slice_b, slice_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_idle", {61'd0, req_ready, resp_valid, busy}, 64'd4);
    end
    run_op(32'h0001_0001, 32'h0002_0002, 1'b0, 0);

    // Randomized operations, mixing in corner operands
    for (int k = 0; k < 40; k++) begin
      ra = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = (($urandom_range(0, 3)) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
